// File: rtl/uart_defs.sv
// Shared UART definitions: transmitter state encoding, parity mode and line levels.
// Used by uart_tx (PARITY state only entered when built with UART_TX_PARITY_EN).
package uart_defs;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_REQ    = 3'd1,
    TX_START  = 3'd2,
    TX_DATA   = 3'd3,
    TX_PARITY = 3'd4,
    TX_STOP   = 3'd5
  } TxState_t;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } Parity_t;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;

  function automatic logic parity_bit(input logic data_xor, input Parity_t mode);
    return data_xor ^ (mode == ODD);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period down-counter: loads div, counts to zero, tick marks the last cycle of a period.
// Shared by the TX serializer and the RX sampler.
module uart_baud_cnt #(
  parameter int DIV_W = 16
) (
  input  logic             tck,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge tck) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= div;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmit serializer with RTS/CTS handshake toward flow control.
// Optional parity bit is compiled in with `define UART_TX_PARITY_EN.
module uart_tx
  import uart_defs::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              tck,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DIV_W-1:0]  baud_div_i,
  input  logic              two_stop_i,
`ifdef UART_TX_PARITY_EN
  input  logic              parity_en_i,
  input  logic              parity_odd_i,
`endif
  input  logic              tx_enable_i,
  output logic              tx_rts_n_o,
  input  logic              tx_cts_n_i,
  output logic              tx_o,
  output logic              busy_o
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  TxState_t          state_q, state_d;
  logic [DATA_W-1:0] shift_q;
  logic [DIV_W-1:0]  div_q;
  logic              two_stop_q;
  logic [IDX_W-1:0]  bit_idx_q;
  logic              stop_idx_q;
  logic              tx_q, tx_d;
  logic              tick, cnt_load, accept, last_bit;
`ifdef UART_TX_PARITY_EN
  logic              par_en_q, par_bit_q;
`endif

  assign accept   = valid_i & tx_enable_i & (state_q == TX_IDLE);
  assign last_bit = (bit_idx_q == IDX_W'(DATA_W - 1));

  uart_baud_cnt #(.DIV_W(DIV_W)) u_baud (
    .tck   (tck),
    .rst_n (rst_n),
    .load  (cnt_load),
    .div   (div_q),
    .tick  (tick)
  );

  // Shadow copy of the word and its framing; frozen for the whole frame.
  always_ff @(posedge tck) begin
    if (accept) begin
      shift_q    <= data_i;
      div_q      <= baud_div_i;
      two_stop_q <= two_stop_i;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= parity_en_i;
      par_bit_q  <= parity_bit(^data_i, Parity_t'(parity_odd_i));
`endif
    end else if (state_q == TX_DATA && tick) begin
      shift_q <= shift_q >> 1;
    end
  end

  always_ff @(posedge tck) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      tx_q    <= UART_IDLE_LVL;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
    end
  end

  always_ff @(posedge tck) begin
    if (!rst_n) begin
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
    end else begin
      if (state_q != TX_DATA) bit_idx_q <= '0;
      else if (tick)          bit_idx_q <= bit_idx_q + 1'b1;
      if (state_q != TX_STOP) stop_idx_q <= 1'b0;
      else if (tick)          stop_idx_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TX_IDLE:  if (accept) state_d = TX_REQ;
      TX_REQ:   if (!tx_cts_n_i && tx_enable_i) state_d = TX_START;
      TX_START: if (tick) state_d = TX_DATA;
`ifdef UART_TX_PARITY_EN
      TX_DATA:   if (tick && last_bit) state_d = par_en_q ? TX_PARITY : TX_STOP;
      TX_PARITY: if (tick) state_d = TX_STOP;
`else
      TX_DATA:  if (tick && last_bit) state_d = TX_STOP;
`endif
      TX_STOP:  if (tick && (stop_idx_q || !two_stop_q)) state_d = TX_IDLE;
      default:  state_d = TX_IDLE;
    endcase
  end

  // Line level is chosen from the next state so tx_o changes on the same edge as the state.
  always_comb begin
    ready_o    = 1'b0;
    tx_rts_n_o = 1'b1;
    busy_o     = 1'b1;
    cnt_load   = 1'b0;
    tx_d       = UART_IDLE_LVL;
    case (state_q)
      TX_IDLE: begin
        ready_o = tx_enable_i;
        busy_o  = 1'b0;
      end
      TX_REQ: begin
        tx_rts_n_o = !tx_enable_i;
        cnt_load   = 1'b1;
      end
      default: begin
        tx_rts_n_o = 1'b0;
        cnt_load   = tick;
      end
    endcase
    case (state_d)
      TX_START:  tx_d = UART_START_LVL;
      TX_DATA:   tx_d = (state_q == TX_DATA && tick) ? shift_q[1] : shift_q[0];
`ifdef UART_TX_PARITY_EN
      TX_PARITY: tx_d = par_bit_q;
`endif
      default:   tx_d = UART_IDLE_LVL;
    endcase
  end

  assign tx_o = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed scenarios plus randomized frames against a frame model.
module tb_uart_tx;

  localparam int DATA_W = 8;
  localparam int DIV_W  = 16;
`ifdef UART_TX_PARITY_EN
  localparam logic HAS_PAR = 1'b1;
`else
  localparam logic HAS_PAR = 1'b0;
`endif

  logic              tck = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] data_i;
  logic              valid_i;
  logic              ready_o;
  logic [DIV_W-1:0]  baud_div_i;
  logic              two_stop_i;
  logic              parity_en_i;
  logic              parity_odd_i;
  logic              tx_enable_i;
  logic              tx_rts_n_o;
  logic              tx_cts_n_i;
  logic              tx_o;
  logic              busy_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 tck = ~tck;

  uart_tx #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
    .tck          (tck),
    .rst_n        (rst_n),
    .data_i       (data_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .baud_div_i   (baud_div_i),
    .two_stop_i   (two_stop_i),
`ifdef UART_TX_PARITY_EN
    .parity_en_i  (parity_en_i),
    .parity_odd_i (parity_odd_i),
`endif
    .tx_enable_i  (tx_enable_i),
    .tx_rts_n_o   (tx_rts_n_o),
    .tx_cts_n_i   (tx_cts_n_i),
    .tx_o         (tx_o),
    .busy_o       (busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Serial bit sequence of one frame, bit i = i-th bit on the line.
  function automatic logic [15:0] frame_model(input logic [7:0] d, input logic pe,
                                              input logic po, input logic ts);
    logic [15:0] v;
    int n;
    v    = '0;
    v[0] = 1'b0;
    for (int i = 0; i < DATA_W; i++) v[1+i] = d[i];
    n = 1 + DATA_W;
    if (pe) begin
      v[n] = (^d) ^ po;
      n++;
    end
    v[n] = 1'b1;
    if (ts) v[n+1] = 1'b1;
    return v;
  endfunction

  task automatic wait_ready();
    int k;
    k = 0;
    while (ready_o !== 1'b1 && k < 200) begin
      @(negedge tck);
      k++;
    end
    chk("ready_wait", 32'(ready_o), 32'(1));
  endtask

  task automatic send(input logic [7:0] d, input int div, input logic ts, input logic pe,
                      input logic po, input int cts_dly, input int req_off, input int drop_at);
    logic [15:0] exp_bits, obs_bits;
    logic bad_hold, bad_ctl;
    int nb, cyc;
    wait_ready();
    data_i       = d;
    baud_div_i   = 16'(div);
    two_stop_i   = ts;
    parity_en_i  = pe;
    parity_odd_i = po;
    valid_i      = 1'b1;
    @(negedge tck);
    valid_i      = 1'b0;
    data_i       = 8'($urandom);
    baud_div_i   = 16'($urandom_range(0, 7));
    two_stop_i   = 1'($urandom_range(0, 1));
    parity_en_i  = 1'($urandom_range(0, 1));
    parity_odd_i = 1'($urandom_range(0, 1));
    chk("req_entry", 32'({tx_o, tx_rts_n_o, busy_o}), 32'(3'b101));
    bad_ctl    = 1'b0;
    tx_cts_n_i = 1'b1;
    repeat (cts_dly) begin
      @(negedge tck);
      if ({tx_o, tx_rts_n_o, busy_o} !== 3'b101) bad_ctl = 1'b1;
    end
    tx_cts_n_i = 1'b0;
    if (req_off > 0) begin
      tx_enable_i = 1'b0;
      repeat (req_off) begin
        @(negedge tck);
        if ({tx_o, tx_rts_n_o, busy_o} !== 3'b111) bad_ctl = 1'b1;
      end
      tx_enable_i = 1'b1;
    end
    chk("req_hold", 32'(bad_ctl), 32'(0));
    @(negedge tck);
    nb       = 1 + DATA_W + int'(pe) + 1 + int'(ts);
    exp_bits = frame_model(d, pe, po, ts);
    obs_bits = '0;
    bad_hold = 1'b0;
    bad_ctl  = 1'b0;
    cyc      = 0;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c <= div; c++) begin
        if (c == 0) obs_bits[b] = tx_o;
        else if (tx_o !== obs_bits[b]) bad_hold = 1'b1;
        if (tx_rts_n_o !== 1'b0 || busy_o !== 1'b1 || ready_o !== 1'b0) bad_ctl = 1'b1;
        if (cyc == drop_at) tx_enable_i = 1'b0;
        cyc++;
        @(negedge tck);
      end
    end
    chk("frame_bits", 32'(obs_bits), 32'(exp_bits));
    chk("bit_period", 32'(bad_hold), 32'(0));
    chk("frame_ctl", 32'(bad_ctl), 32'(0));
    chk("post_idle", 32'({tx_o, tx_rts_n_o, busy_o, ready_o}),
        32'({1'b1, 1'b1, 1'b0, tx_enable_i}));
  endtask

  initial begin
    logic bad;
    logic [15:0] f;
    logic exp_tx[$];
    logic exp_rts[$];

    rst_n        = 1'b0;
    valid_i      = 1'b0;
    data_i       = '0;
    baud_div_i   = '0;
    two_stop_i   = 1'b0;
    parity_en_i  = 1'b0;
    parity_odd_i = 1'b0;
    tx_enable_i  = 1'b0;
    tx_cts_n_i   = 1'b1;
    repeat (3) @(negedge tck);
    chk("reset_out", 32'({tx_o, tx_rts_n_o, busy_o, ready_o}), 32'(4'b1100));
    rst_n       = 1'b1;
    tx_enable_i = 1'b1;
    @(negedge tck);
    chk("idle_ready", 32'(ready_o), 32'(1));

    // Basic frame, CTS already low
    tx_cts_n_i = 1'b0;
    send(8'hA5, 3, 1'b0, 1'b0, 1'b0, 0, 0, -1);
    // CTS held off 20 cycles, then enable low for 5 cycles inside REQ
    send(8'h3C, 1, 1'b0, 1'b0, 1'b0, 20, 5, -1);
    // Parity (when built in) and two stop bits
    send(8'h07, 2, 1'b1, HAS_PAR, 1'b1, 1, 0, -1);
    send(8'h07, 2, 1'b1, HAS_PAR, 1'b0, 0, 0, -1);
    // Enable dropped in the middle of the data bits
    send(8'h96, 2, 1'b0, 1'b0, 1'b0, 0, 0, 14);
    bad = 1'b0;
    repeat (5) begin
      @(negedge tck);
      if (ready_o !== 1'b0 || busy_o !== 1'b0) bad = 1'b1;
    end
    chk("en_low_ready", 32'(bad), 32'(0));
    tx_enable_i = 1'b1;
    @(negedge tck);

    for (int i = 0; i < 10; i++) begin
      send(8'($urandom), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
           HAS_PAR & 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), -1);
    end

    // Reset while shifting data bits
    wait_ready();
    data_i      = 8'h00;
    baud_div_i  = 16'd3;
    two_stop_i  = 1'b0;
    parity_en_i = 1'b0;
    tx_cts_n_i  = 1'b0;
    valid_i     = 1'b1;
    @(negedge tck);
    valid_i = 1'b0;
    repeat (13) @(negedge tck);
    chk("rst_pre", 32'({tx_o, busy_o}), 32'(2'b01));
    rst_n = 1'b0;
    @(negedge tck);
    chk("rst_mid", 32'({tx_o, tx_rts_n_o, busy_o}), 32'(3'b110));
    rst_n = 1'b1;
    bad   = 1'b0;
    repeat (40) begin
      @(negedge tck);
      if ({tx_o, busy_o, tx_rts_n_o} !== 3'b101) bad = 1'b1;
    end
    chk("rst_no_residual", 32'(bad), 32'(0));

    // Back-to-back words with valid held high and CTS low
    wait_ready();
    baud_div_i  = 16'd0;
    two_stop_i  = 1'b0;
    parity_en_i = 1'b0;
    data_i      = 8'h00;
    valid_i     = 1'b1;
    @(negedge tck);
    exp_tx.push_back(1'b1); exp_rts.push_back(1'b0);
    f = frame_model(8'h00, 1'b0, 1'b0, 1'b0);
    for (int b = 0; b < 10; b++) begin exp_tx.push_back(f[b]); exp_rts.push_back(1'b0); end
    exp_tx.push_back(1'b1); exp_rts.push_back(1'b1);
    exp_tx.push_back(1'b1); exp_rts.push_back(1'b0);
    f = frame_model(8'hFF, 1'b0, 1'b0, 1'b0);
    for (int b = 0; b < 10; b++) begin exp_tx.push_back(f[b]); exp_rts.push_back(1'b0); end
    repeat (3) begin exp_tx.push_back(1'b1); exp_rts.push_back(1'b1); end
    for (int c = 0; c < exp_tx.size(); c++) begin
      chk("b2b_tx", 32'(tx_o), 32'(exp_tx[c]));
      chk("b2b_rts", 32'(tx_rts_n_o), 32'(exp_rts[c]));
      if (c == 0) data_i = 8'hFF;
      if (c == 12) valid_i = 1'b0;
      @(negedge tck);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
